// File: rtl/proc_pkg.sv
// Shared processor-wide sizing defaults and the register address type.
package proc_pkg;

  localparam int unsigned PROC_DATA_W   = 16;
  localparam int unsigned PROC_NUM_REGS = 8;
  localparam int unsigned PROC_AW       = $clog2(PROC_NUM_REGS);

  typedef logic [PROC_AW-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for outstanding writebacks, with an incrementally
// maintained population count.
module regfile_scoreboard #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ZERO_REG = 0,
  localparam int unsigned AW = $clog2(NUM_REGS),
  localparam int unsigned CW = $clog2(NUM_REGS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  input  logic                we,
  input  logic [AW-1:0]       rd,
  output logic [NUM_REGS-1:0] pending,
  output logic [CW-1:0]       pend_cnt
);

  logic [NUM_REGS-1:0] r_pending;
  logic [CW-1:0]       r_cnt;
  logic [NUM_REGS-1:0] w_pending_d;
  logic [CW-1:0]       w_cnt_d;
  logic                w_set;
  logic                w_set_new;
  logic                w_clr;

  always_comb begin
    w_set     = issue_valid && !((ZERO_REG != 0) && (issue_rd == '0));
    w_set_new = w_set && !r_pending[issue_rd];
    // A clear that collides with a set on the same register loses to the set.
    w_clr     = we && r_pending[rd] && !(w_set && (issue_rd == rd));

    w_pending_d = r_pending;
    if (we)    w_pending_d[rd]       = 1'b0;
    if (w_set) w_pending_d[issue_rd] = 1'b1;

    w_cnt_d = r_cnt;
    if (w_set_new && !w_clr)      w_cnt_d = r_cnt + CW'(1);
    else if (!w_set_new && w_clr) w_cnt_d = r_cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_cnt     <= '0;
    end else begin
      r_pending <= w_pending_d;
      r_cnt     <= w_cnt_d;
    end
  end

  assign pending  = r_pending;
  assign pend_cnt = r_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with same-cycle write bypass and a
// writeback scoreboard reporting busy source operands.
module regfile_sb
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W   = PROC_DATA_W,
  parameter int unsigned NUM_REGS = PROC_NUM_REGS,
  parameter int unsigned ZERO_REG = 0,
  localparam int unsigned AW = $clog2(NUM_REGS),
  localparam int unsigned CW = $clog2(NUM_REGS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     rs1,
  input  logic [AW-1:0]     rs2,
  output logic [DATA_W-1:0] data_rs1,
  output logic [DATA_W-1:0] data_rs2,
  input  logic              we,
  input  logic [AW-1:0]     rd,
  input  logic [DATA_W-1:0] data_in,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic [CW-1:0]     pend_cnt
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] w_pending;
  logic                w_wr;
  logic                w_zero_rs1;
  logic                w_zero_rs2;

  assign w_wr       = we && !((ZERO_REG != 0) && (rd == '0));
  assign w_zero_rs1 = (ZERO_REG != 0) && (rs1 == '0);
  assign w_zero_rs2 = (ZERO_REG != 0) && (rs2 == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[rd] <= data_in;
    end
  end

  always_comb begin
    data_rs1 = r_regs[rs1];
    if (w_zero_rs1)                data_rs1 = '0;
    else if (w_wr && (rd == rs1))  data_rs1 = data_in;
  end

  always_comb begin
    data_rs2 = r_regs[rs2];
    if (w_zero_rs2)                data_rs2 = '0;
    else if (w_wr && (rd == rs2))  data_rs2 = data_in;
  end

  // A writeback landing this cycle satisfies the operand through the bypass.
  assign rs1_busy = w_pending[rs1] && !(we && (rd == rs1));
  assign rs2_busy = w_pending[rs2] && !(we && (rd == rs2));

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .we          (we),
    .rd          (rd),
    .pending     (w_pending),
    .pend_cnt    (pend_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a vector table on the plain instance plus
// hand sequences for reset and the zero-register variant.
module tb_regfile_sb;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  reg_addr_t   rd;
  logic [15:0] data_in;
  logic        issue_valid;
  reg_addr_t   issue_rd;
  reg_addr_t   rs1;
  reg_addr_t   rs2;

  logic [15:0] d_rs1, d_rs2, z_rs1, z_rs2;
  logic        d_b1, d_b2, z_b1, z_b2;
  logic [3:0]  d_cnt, z_cnt;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(16), .NUM_REGS(8), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .data_rs1(d_rs1), .data_rs2(d_rs2),
    .we(we), .rd(rd), .data_in(data_in), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_busy(d_b1), .rs2_busy(d_b2), .pend_cnt(d_cnt)
  );

  regfile_sb #(.DATA_W(16), .NUM_REGS(8), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .data_rs1(z_rs1), .data_rs2(z_rs2),
    .we(we), .rd(rd), .data_in(data_in), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_busy(z_b1), .rs2_busy(z_b2), .pend_cnt(z_cnt)
  );

  typedef struct {
    logic        rst;
    logic        we;
    reg_addr_t   rd;
    logic [15:0] din;
    logic        iv;
    reg_addr_t   ird;
    reg_addr_t   rs1;
    reg_addr_t   rs2;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        b1;
    logic        b2;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input int r, w, a, din, iv, ia, s1, s2, e1, e2, b1, b2, c);
    vec_t v;
    v.rst = 1'(r);    v.we  = 1'(w);           v.rd  = reg_addr_t'(a);
    v.din = 16'(din); v.iv  = 1'(iv);          v.ird = reg_addr_t'(ia);
    v.rs1 = reg_addr_t'(s1); v.rs2 = reg_addr_t'(s2);
    v.e1  = 16'(e1);  v.e2  = 16'(e2);
    v.b1  = 1'(b1);   v.b2  = 1'(b2);          v.cnt = 4'(c);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, w, input int a, din, input logic iv, input int ia,
                       input int s1, s2);
    rst = r; we = w; rd = reg_addr_t'(a); data_in = 16'(din);
    issue_valid = iv; issue_rd = reg_addr_t'(ia);
    rs1 = reg_addr_t'(s1); rs2 = reg_addr_t'(s2);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    //      rst we rd din     iv ird rs1 rs2 e1      e2      b1 b2 cnt
    tv.push_back(mk(1, 1, 1, 'hAAAA, 0, 0, 1, 2, 'hAAAA, 0,      0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,      0, 0, 1, 3, 0,      0,      0, 0, 0));
    tv.push_back(mk(0, 1, 3, 'hBEEF, 0, 0, 0, 0, 0,      0,      0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,      0, 0, 3, 5, 'hBEEF, 0,      0, 0, 0));
    tv.push_back(mk(0, 1, 5, 'h1234, 0, 0, 3, 5, 'hBEEF, 'h1234, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,      1, 2, 2, 5, 0,      'h1234, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,      0, 0, 2, 5, 0,      'h1234, 1, 0, 1));
    tv.push_back(mk(0, 1, 2, 'h2222, 0, 0, 2, 5, 'h2222, 'h1234, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0,      0, 0, 2, 5, 'h2222, 'h1234, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,      1, 4, 4, 4, 0,      0,      0, 0, 0));
    tv.push_back(mk(0, 1, 4, 'h4444, 1, 4, 4, 4, 'h4444, 'h4444, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0,      0, 0, 4, 4, 'h4444, 'h4444, 1, 1, 1));
    tv.push_back(mk(0, 1, 6, 'h6666, 1, 7, 6, 4, 'h6666, 'h4444, 0, 1, 1));
    tv.push_back(mk(0, 0, 0, 0,      0, 0, 6, 7, 'h6666, 0,      0, 1, 2));
    tv.push_back(mk(0, 1, 7, 'h7777, 1, 1, 1, 7, 0,      'h7777, 0, 0, 2));
    tv.push_back(mk(0, 0, 0, 0,      0, 0, 1, 7, 0,      'h7777, 1, 0, 2));
    tv.push_back(mk(0, 1, 0, 'h0F0F, 0, 0, 0, 0, 'h0F0F, 'h0F0F, 0, 0, 2));
    tv.push_back(mk(0, 0, 0, 0,      0, 0, 0, 3, 'h0F0F, 'hBEEF, 0, 0, 2));

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].we, int'(tv[i].rd), int'(tv[i].din), tv[i].iv, int'(tv[i].ird),
            int'(tv[i].rs1), int'(tv[i].rs2));
      @(negedge clk);
      chk($sformatf("v%0d data_rs1", i), 32'(d_rs1), 32'(tv[i].e1));
      chk($sformatf("v%0d data_rs2", i), 32'(d_rs2), 32'(tv[i].e2));
      chk($sformatf("v%0d rs1_busy", i), 32'(d_b1), 32'(tv[i].b1));
      chk($sformatf("v%0d rs2_busy", i), 32'(d_b2), 32'(tv[i].b2));
      chk($sformatf("v%0d pend_cnt", i), 32'(d_cnt), 32'(tv[i].cnt));
      next_cycle();
    end

    // Fill the scoreboard: no wrap at NUM_REGS, zero-reg variant stops at 7.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 1, i, 0, 0);
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("full pend_cnt", 32'(d_cnt), 32'd8);
    chk("full pend_cnt zero-reg", 32'(z_cnt), 32'd7);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 0, 0, i, 7 - i);
      @(negedge clk);
      chk($sformatf("full rs1_busy r%0d", i), 32'(d_b1), 32'd1);
      chk($sformatf("full rs1_busy zero-reg r%0d", i), 32'(z_b1), (i != 0) ? 32'd1 : 32'd0);
      next_cycle();
    end

    // Reset with a colliding write and issue in flight; reset wins at the edge.
    drive(1, 1, 3, 'h5555, 1, 3, 3, 2);
    @(negedge clk);
    chk("rst bypass data_rs1", 32'(d_rs1), 32'h5555);
    chk("rst rs1_busy", 32'(d_b1), 32'd0);
    chk("rst rs2_busy", 32'(d_b2), 32'd1);
    next_cycle();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 0, 0, i, 7 - i);
      @(negedge clk);
      chk($sformatf("post-rst pend_cnt %0d", i), 32'(d_cnt), 32'd0);
      chk($sformatf("post-rst data_rs1 r%0d", i), 32'(d_rs1), 32'd0);
      chk($sformatf("post-rst data_rs2 r%0d", 7 - i), 32'(d_rs2), 32'd0);
      chk($sformatf("post-rst busy r%0d", i), 32'({d_b1, d_b2, z_b1, z_b2}), 32'd0);
      next_cycle();
    end
    chk("post-rst pend_cnt zero-reg", 32'(z_cnt), 32'd0);

    // Register 0 write and issue together: suppressed only on the zero-reg variant.
    drive(0, 1, 0, 'hFFFF, 1, 0, 0, 1);
    @(negedge clk);
    chk("r0 bypass zero-reg", 32'(z_rs1), 32'd0);
    chk("r0 bypass plain", 32'(d_rs1), 32'hFFFF);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("r0 read zero-reg", 32'(z_rs1), 32'd0);
    chk("r0 pend_cnt zero-reg", 32'(z_cnt), 32'd0);
    chk("r0 busy zero-reg", 32'(z_b1), 32'd0);
    chk("r0 read plain", 32'(d_rs1), 32'hFFFF);
    chk("r0 pend_cnt plain", 32'(d_cnt), 32'd1);
    chk("r0 busy plain", 32'(d_b1), 32'd1);
    next_cycle();

    // Mid-operation reset drops pending state; the later writeback is a plain write.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    drive(0, 1, 0, 'h0001, 0, 0, 1, 0);
    @(negedge clk);
    chk("late wb pend_cnt", 32'(d_cnt), 32'd0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("late wb pend_cnt after", 32'(d_cnt), 32'd0);
    chk("late wb data", 32'(d_rs1), 32'h0001);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
